// File: rtl/univ_shift_reg_seq.sv
// rtl/univ_shift_reg_seq.sv - universal shift register, multi-bit shifts run one bit per cycle
module univ_shift_reg_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CW-1:0]    shamt,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_SRA  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ROR  = 3'b110;

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  q_n;
  logic              sout_n, busy_n, done_n;
  logic [CW-1:0]     count, count_n;
  logic [2:0]        mode_r, mode_n;
  logic              is_shift;
  logic [CW-1:0]     shamt_clamped;

  assign is_shift      = (mode == M_SHL) || (mode == M_SHR) || (mode == M_SRA) ||
                         (mode == M_ROL) || (mode == M_ROR);
  assign shamt_clamped = (shamt > WIDTH_C) ? WIDTH_C : shamt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      q      <= '0;
      sout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
      mode_r <= M_HOLD;
    end else begin
      state  <= state_n;
      q      <= q_n;
      sout   <= sout_n;
      busy   <= busy_n;
      done   <= done_n;
      count  <= count_n;
      mode_r <= mode_n;
    end
  end

  always_comb begin
    state_n = state;
    q_n     = q;
    sout_n  = sout;
    busy_n  = busy;
    done_n  = 1'b0;
    count_n = count;
    mode_n  = mode_r;

    if (clr) begin
      state_n = IDLE;
      q_n     = '0;
      sout_n  = 1'b0;
      busy_n  = 1'b0;
      count_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (mode == M_LOAD) begin
              q_n    = d;
              done_n = 1'b1;
            end else if (is_shift && (shamt != '0)) begin
              count_n = shamt_clamped;
              mode_n  = mode;
              busy_n  = 1'b1;
              state_n = SHIFT;
            end else begin
              // hold, reserved, or a zero-length shift completes immediately
              done_n = 1'b1;
            end
          end
        end
        SHIFT: begin
          case (mode_r)
            M_SHL: begin
              q_n    = {q[WIDTH-2:0], sin};
              sout_n = q[WIDTH-1];
            end
            M_SHR: begin
              q_n    = {sin, q[WIDTH-1:1]};
              sout_n = q[0];
            end
            M_SRA: begin
              q_n    = {q[WIDTH-1], q[WIDTH-1:1]};
              sout_n = q[0];
            end
            M_ROL: begin
              q_n    = {q[WIDTH-2:0], q[WIDTH-1]};
              sout_n = q[WIDTH-1];
            end
            M_ROR: begin
              q_n    = {q[0], q[WIDTH-1:1]};
              sout_n = q[0];
            end
            default: q_n = q;
          endcase
          count_n = count - 1'b1;
          if (count == CW'(1)) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// tb/tb_univ_shift_reg_seq.sv - directed bench for univ_shift_reg_seq
module tb_univ_shift_reg_seq;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n, clr, start, sin;
  logic [2:0]       mode;
  logic [CW-1:0]    shamt;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             sout, busy, done;

  int passed = 0;
  int total  = 0;
  int bc;

  univ_shift_reg_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .mode(mode),
    .shamt(shamt), .d(d), .sin(sin), .q(q), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic go(input logic [2:0] m, input logic [CW-1:0] n, input logic [WIDTH-1:0] dv);
    start = 1'b1;
    mode  = m;
    shamt = n;
    d     = dv;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; start = 1'b0; sin = 1'b0;
    mode = 3'd0; shamt = '0; d = '0;
    tick();
    check("rst_q", q, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sout", sout, 0);
    rst_n = 1'b1;
    tick();

    // load
    go(3'd1, 0, 8'hA5);
    tick(); start = 1'b0;
    check("load_q", q, 8'hA5);
    check("load_done", done, 1);
    check("load_busy", busy, 0);
    tick();
    check("load_done_drop", done, 0);
    check("load_busy_idle", busy, 0);

    // shl by 3 with sin=1
    sin = 1'b1;
    go(3'd2, 3, 8'h00);
    tick(); start = 1'b0;
    check("shl_k_q", q, 8'hA5);
    check("shl_k_busy", busy, 1);
    check("shl_k_done", done, 0);
    tick();
    check("shl_1_q", q, 8'h4B);
    check("shl_1_sout", sout, 1);
    tick();
    check("shl_2_q", q, 8'h97);
    check("shl_2_sout", sout, 0);
    tick();
    check("shl_3_q", q, 8'h2F);
    check("shl_3_sout", sout, 1);
    check("shl_3_done", done, 1);
    check("shl_3_busy", busy, 0);
    tick();
    check("shl_done_drop", done, 0);

    // sra by 2, then ror by 1 launched in the done cycle
    sin = 1'b0;
    go(3'd1, 0, 8'h81);
    tick(); start = 1'b0;
    check("load81_q", q, 8'h81);
    go(3'd4, 2, 8'h00);
    tick(); start = 1'b0;
    tick();
    check("sra_1_q", q, 8'hC0);
    check("sra_1_sout", sout, 1);
    tick();
    check("sra_2_q", q, 8'hE0);
    check("sra_2_sout", sout, 0);
    check("sra_2_done", done, 1);
    go(3'd6, 1, 8'h00);
    tick(); start = 1'b0;
    check("ror_k_busy", busy, 1);
    check("ror_k_q", q, 8'hE0);
    tick();
    check("ror_q", q, 8'h70);
    check("ror_sout", sout, 0);
    check("ror_done", done, 1);

    // rol clamped to WIDTH
    go(3'd1, 0, 8'h3C);
    tick(); start = 1'b0;
    go(3'd5, 12, 8'h00);
    tick(); start = 1'b0;
    bc = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) bc++;
      tick();
    end
    check("rol_busy_cycles", bc, 8);
    check("rol_busy_end", busy, 0);
    check("rol_done", done, 1);
    check("rol_q", q, 8'h3C);
    check("rol_sout", sout, 0);

    // zero-length shift
    go(3'd2, 0, 8'h00);
    tick(); start = 1'b0;
    check("shamt0_done", done, 1);
    check("shamt0_busy", busy, 0);
    check("shamt0_q", q, 8'h3C);
    tick();
    check("shamt0_done_drop", done, 0);

    // start during a shift is ignored; back-to-back start in done cycle
    go(3'd2, 5, 8'h00);
    tick(); start = 1'b0;
    tick();
    go(3'd1, 0, 8'hFF);
    tick(); start = 1'b0;
    check("ign_busy", busy, 1);
    check("ign_q", q, 8'hF0);
    tick(); tick(); tick();
    check("ign_final_q", q, 8'h80);
    check("ign_done", done, 1);
    go(3'd1, 0, 8'h5A);
    tick(); start = 1'b0;
    check("b2b_q", q, 8'h5A);
    check("b2b_done", done, 1);

    // async reset mid-shift
    go(3'd3, 6, 8'h00);
    tick(); start = 1'b0;
    tick();
    check("shr_1_q", q, 8'h2D);
    tick();
    check("shr_2_q", q, 8'h16);
    check("shr_2_sout", sout, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_q", q, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sout", sout, 0);
    rst_n = 1'b1;
    tick();

    // synchronous clear mid-shift with a competing start
    go(3'd1, 0, 8'h5A);
    tick(); start = 1'b0;
    go(3'd3, 6, 8'h00);
    tick(); start = 1'b0;
    tick(); tick();
    check("pre_clr_busy", busy, 1);
    clr = 1'b1;
    go(3'd1, 0, 8'hFF);
    tick();
    clr = 1'b0; start = 1'b0;
    check("clr_q", q, 0);
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_sout", sout, 0);
    tick();
    check("post_clr_q", q, 0);
    check("post_clr_busy", busy, 0);
    check("post_clr_done", done, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg_seq.md
Name: univ_shift_reg_seq

Overview:
Parametrised universal shift register with an 8-mode operation set and a multi-bit shift amount. Multi-bit shifts are executed one bit per cycle under a start/busy/done handshake. Serial in/out is provided for chaining. This block is the successor to the fixed 8-bit, 4-mode shift register. It sits in datapath blocks that need variable logical, arithmetic or rotate shifts without a barrel shifter.

Parameters:
WIDTH, 8, register width in bits (WIDTH >= 2)
CW, $clog2(WIDTH)+1, width of shamt and internal counter (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear; highest priority after reset
start  input  1  request operation; accepted only in IDLE
mode  input  3  operation select, captured on accepted start
shamt  input  CW  shift count, captured on accepted start
d  input  WIDTH  parallel load data
sin  input  1  serial fill bit for logical shifts
q  output  WIDTH  register contents
sout  output  1  last bit shifted out
busy  output  1  high while a multi-cycle shift is in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst_n=0, async): q=0, sout=0, busy=0, done=0, count=0, state=IDLE. Outputs go to these values immediately, including mid-shift.
- clr=1 at an edge:
  - q=0, sout=0, busy=0, done=0, state=IDLE.
  - Any shift in progress is aborted.
  - start is ignored at that edge.
- Modes:
  - 000 hold
  - 001 load (q<=d)
  - 010 shl (fill LSB with sin)
  - 011 shr (fill MSB with sin)
  - 100 sra (fill MSB with q[WIDTH-1])
  - 101 rol
  - 110 ror
  - 111 reserved, behaves as hold
- done defaults to 0 every cycle unless set as described below.
- States: IDLE, SHIFT.
- IDLE, start=1, at edge k:
  - hold, reserved, or shift mode with shamt=0: q unchanged; done=1 after edge k; stay IDLE.
  - load: q<=d at edge k; done=1 after edge k; busy stays 0.
  - shift mode with shamt>0: count<=min(shamt, WIDTH); latch mode; busy<=1; go to SHIFT. q is unchanged at edge k.
- SHIFT, each edge:
  - q<=one-bit shift of q per the latched mode.
  - sout<=bit leaving q: q[WIDTH-1] for shl/rol, q[0] for shr/sra/ror.
  - count<=count-1.
  - When count==1: busy<=0, done<=1, state<=IDLE.
- Latency for shift of N (after clamp): q is final after edge k+N; done is high for exactly the cycle after edge k+N; busy is high from after edge k through edge k+N.
- start while busy is ignored, and mode, shamt and d changes are ignored. The next start is accepted in the cycle done is high (back-to-back allowed).
- shamt > WIDTH is clamped to WIDTH. Rotate by WIDTH returns the original value.
- sout holds its value when not shifting. Load does not change sout.
- sin is sampled on every shift edge, not captured at start.

Test Plan:
- WIDTH=8; load d=0xA5 -> q=0xA5 after start edge; done pulses 1 cycle; busy never high.
- From q=0xA5: shl, shamt=3, sin=1 -> q=0x4B, 0x97, 0x2F on successive edges; busy high 3 cycles; done on 4th cycle; sout=1.
- Load 0x81, then sra, shamt=2 -> q=0xC0, then 0xE0; sout=0. Then ror, shamt=1 -> q=0x70, sout=0.
- Load 0x3C, then rol, shamt=12 (clamped to 8) -> busy exactly 8 cycles; q=0x3C at done. Also: shamt=0 in shl mode -> done next cycle, q unchanged, busy stays 0.
- Start pulse with d=0xFF, mode=load during a shamt=5 shift -> ignored; shift completes normally. A new start in the done cycle is accepted.
- During a shr with shamt=6: drop rst_n mid-shift -> q=0, busy=0, done=0 immediately, without waiting for a clock edge. Repeat using clr=1 -> same values at the next edge; start asserted in the same cycle is ignored.
